decode_stage: RTL and testbench
===============================

# decode_stage

Second pipeline stage of the 16-bit CPU: holds the IF/ID pipeline register, decodes the 4-bit opcode, reads the register file, resolves branches, and drives `br_sig`/`src_data1` back to instruction fetch. Detects load-use and flag hazards, inserting single-cycle bubbles and a PC stall. On a taken branch it flushes the wrong-path instruction. On HLT it freezes the front end. Outputs go to execute through a registered ID/EX bundle.

## Interface
- `NOP_INSTR`, default 16'h0000: instruction word held in IF/ID when the slot is invalid.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `if_pc` in 16: PC+2 of the fetched instruction, from IF.
- `if_instr` in 16: fetched instruction, from IF.
- `flag_bits` in 3: {Z,V,N} from the flag register.
- `ex_mem_read` in 1: the instruction currently in EX is LW.
- `ex_sets_flags` in 1: the EX instruction writes flags.
- `ex_rd` in 4: destination register of the EX instruction.
- `rf_data1` in 16: register-file read port 1 data.
- `rf_data2` in 16: register-file read port 2 data.
- `rf_addr1` out 4: register-file read address 1.
- `rf_addr2` out 4: register-file read address 2.
- `pc_write_en` out 1: 0 holds the PC in IF.
- `br_sig` out 2: 00 sequential, 01 B (PC-relative), 10 BR (register target); nonzero only when the branch is taken.
- `src_data1` out 16: BR target, equal to `rf_data1`.
- `idex_valid` out 1: registered; ID/EX slot holds a real instruction.
- `idex_opcode` out 4: registered opcode.
- `idex_rd` out 4: registered destination register.
- `idex_data1` out 16: registered read data 1.
- `idex_data2` out 16: registered read data 2.
- `idex_imm` out 16: registered, sign-/zero-extended immediate.
- `idex_pc` out 16: registered PC+2.
- `idex_reg_write` out 1: registered control bit.
- `idex_mem_read` out 1: registered control bit.
- `idex_mem_write` out 1: registered control bit.
- `idex_halt` out 1: registered control bit.

## Operation
- **Opcode map:**
  - 0–7 are ALU ops, with rd=[11:8], rs=[7:4], rt=[3:0].
  - 8 is LW and 9 is SW: rt=[11:8], rs=[7:4], imm = sext([3:0])<<1.
  - 10 is LLB and 11 is LHB: rd=[11:8], imm8=[7:0], and rs = rd.
  - 12 is B, 13 is BR (rs=[7:4]), 14 is PCS, 15 is HLT.
- **Read addresses:**
  - `rf_addr1` = rs.
  - `rf_addr2` = [3:0] for opcodes 0–7; otherwise [11:8].
- **Branch condition** C=[11:9], evaluated on `flag_bits`:
  - 000 NE (!Z), 001 EQ (Z), 010 GT (!Z&!N), 011 LT (N).
  - 100 GE (Z|!N), 101 LE (Z|N), 110 OV (V), 111 always.
- **Load-use hazard:** `ex_mem_read`, the IF/ID slot is valid, and `ex_rd` matches a source register actually used by the instruction.
- **Flag hazard:** `ex_sets_flags` while a valid B or BR is in IF/ID.
- **On a hazard (stall):**
  - `pc_write_en`=0.
  - The IF/ID register holds.
  - ID/EX loads a bubble (valid=0, all control bits 0).
  - `br_sig`=00.
- **Taken branch** (valid, no stall, condition true):
  - `br_sig` is set.
  - On the next edge IF/ID loads `NOP_INSTR` with valid=0 (flush).
- **State machine:**
  - RUN → HALT when a valid, unstalled HLT is issued to ID/EX.
  - In HALT: `pc_write_en`=0, IF/ID frozen, ID/EX bubbles, `br_sig`=00.
  - HALT is left only by `rst`.
- **Per-edge priority:** rst > HALT > stall > flush > normal load.

## Timing
- All `idex_*` outputs and IF/ID are updated on the rising edge of `clk`.
- `rf_addr*`, `br_sig`, `src_data1` and `pc_write_en` are combinational from IF/ID and the hazard inputs, settling in the same cycle.
- Decode latency is one cycle: IF/ID → ID/EX.
- Load-use costs exactly 1 bubble. The next cycle, with `ex_mem_read`=0, issues normally.
- A taken branch costs 1 flushed slot.
- Stall and taken branch in the same cycle: the stall wins and the branch re-resolves next cycle with updated flags.
- **Reset values:**
  - IF/ID valid=0 and instruction=`NOP_INSTR`.
  - All `idex_*`=0.
  - State=RUN.
  - `pc_write_en`=1 and `br_sig`=00.
- An asserted `rst` mid-stall or in HALT returns the block to these values immediately (asynchronously).

## Structure
- The shared package `cpu_pkg` holds:
  - the opcode constants;
  - the `br_sig` encodings;
  - the condition-code constants;
  - the state enum {RUN, HALT}.
- One sub-module, `hazard_unit`, is purely combinational: it produces `stall` and `taken` from the decoded fields, `ex_*` and `flag_bits`.
- The pipeline registers and the FSM stay in `decode_stage`.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` mid-cycle while `if_instr`=16'h1234.
  - Expected: `idex_valid`=0, `pc_write_en`=1, `br_sig`=00 immediately.
- **ALU decode:**
  - Stimulus: `if_instr`=16'h0123 with rf returning 5 and 7.
  - Expected: `rf_addr1`=2, `rf_addr2`=3; next edge `idex_rd`=1, `idex_data1`=5, `idex_data2`=7, `idex_reg_write`=1.
- **Load-use:**
  - Stimulus: `ex_mem_read`=1, `ex_rd`=2, instruction 16'h0123.
  - Expected: `pc_write_en`=0 for one cycle, one bubble (`idex_valid`=0), then issue.
- **Taken branch:**
  - Stimulus: B EQ (16'hC20A) with Z=1.
  - Expected: `br_sig`=01; the next IF/ID slot is invalid.
  - Repeat with Z=0: expect `br_sig`=00 and no flush.
- **BR and flag hazard:**
  - Stimulus: BR 16'hDE30 (always) with `ex_sets_flags`=1.
  - Expected: one stall, then `br_sig`=10 and `src_data1`=`rf_data1`.
- **HLT:**
  - Stimulus: 16'hF000.
  - Expected: `idex_halt`=1 once, then `pc_write_en`=0 and bubbles indefinitely until `rst`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, br_sig encodings, condition codes, decode FSM states
// and the ID/EX bundle layout.
package cpu_pkg;

  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;
  localparam logic [3:0] OP_LLB = 4'd10;
  localparam logic [3:0] OP_LHB = 4'd11;
  localparam logic [3:0] OP_B   = 4'd12;
  localparam logic [3:0] OP_BR  = 4'd13;
  localparam logic [3:0] OP_PCS = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam logic [1:0] BR_SEQ = 2'b00;
  localparam logic [1:0] BR_REL = 2'b01;
  localparam logic [1:0] BR_REG = 2'b10;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_AL = 3'b111;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
  } idex_t;

  // flags are {Z,V,N}
  function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] flags);
    logic z, v, n;
    z = flags[2];
    v = flags[1];
    n = flags[0];
    case (cond)
      CC_NE:   cond_true = !z;
      CC_EQ:   cond_true = z;
      CC_GT:   cond_true = !z && !n;
      CC_LT:   cond_true = n;
      CC_GE:   cond_true = z || !n;
      CC_LE:   cond_true = z || n;
      CC_OV:   cond_true = v;
      default: cond_true = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection and branch resolution for the instruction held in IF/ID.
module hazard_unit
  import cpu_pkg::*;
(
  input  logic       valid,
  input  logic [3:0] opcode,
  input  logic [3:0] src1,
  input  logic [3:0] src2,
  input  logic [2:0] cond,
  input  logic [2:0] flag_bits,
  input  logic       ex_mem_read,
  input  logic       ex_sets_flags,
  input  logic [3:0] ex_rd,
  output logic       stall,
  output logic       taken
);

  logic uses1, uses2, is_branch, load_use, flag_haz;

  always_comb begin
    // B, PCS and HLT read no registers; only ALU ops and SW read the second port
    uses1     = (opcode != OP_B) && (opcode != OP_PCS) && (opcode != OP_HLT);
    uses2     = (opcode < OP_LW) || (opcode == OP_SW);
    is_branch = (opcode == OP_B) || (opcode == OP_BR);
    load_use  = valid && ex_mem_read &&
                ((uses1 && (ex_rd == src1)) || (uses2 && (ex_rd == src2)));
    flag_haz  = valid && ex_sets_flags && is_branch;
    stall     = load_use || flag_haz;
    taken     = valid && is_branch && !stall && cond_true(cond, flag_bits);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, decode, branch resolution, hazard stalls, HLT freeze and
// the registered ID/EX bundle.
//   state | meaning
//   RUN   | normal issue; stalls and flushes handled per edge
//   HALT  | HLT issued; PC held, IF/ID frozen, ID/EX bubbles until rst
module decode_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] if_pc,
  input  logic [15:0] if_instr,
  input  logic [2:0]  flag_bits,
  input  logic        ex_mem_read,
  input  logic        ex_sets_flags,
  input  logic [3:0]  ex_rd,
  input  logic [15:0] rf_data1,
  input  logic [15:0] rf_data2,
  output logic [3:0]  rf_addr1,
  output logic [3:0]  rf_addr2,
  output logic        pc_write_en,
  output logic [1:0]  br_sig,
  output logic [15:0] src_data1,
  output logic        idex_valid,
  output logic [3:0]  idex_opcode,
  output logic [3:0]  idex_rd,
  output logic [15:0] idex_data1,
  output logic [15:0] idex_data2,
  output logic [15:0] idex_imm,
  output logic [15:0] idex_pc,
  output logic        idex_reg_write,
  output logic        idex_mem_read,
  output logic        idex_mem_write,
  output logic        idex_halt
);

  state_t      state, next_state;
  logic        ifid_valid;
  logic [15:0] ifid_instr, ifid_pc;
  idex_t       idex_q, idex_next;

  logic [3:0]  op;
  logic [15:0] imm;
  logic        stall, taken, halted, br_taken, issue;

  hazard_unit u_hazard (
    .valid         (ifid_valid),
    .opcode        (op),
    .src1          (rf_addr1),
    .src2          (rf_addr2),
    .cond          (ifid_instr[11:9]),
    .flag_bits     (flag_bits),
    .ex_mem_read   (ex_mem_read),
    .ex_sets_flags (ex_sets_flags),
    .ex_rd         (ex_rd),
    .stall         (stall),
    .taken         (taken)
  );

  always_comb begin
    op       = ifid_instr[15:12];
    rf_addr1 = ((op == OP_LLB) || (op == OP_LHB)) ? ifid_instr[11:8] : ifid_instr[7:4];
    rf_addr2 = (op < OP_LW) ? ifid_instr[3:0] : ifid_instr[11:8];
    case (op)
      OP_LW, OP_SW:   imm = {{11{ifid_instr[3]}}, ifid_instr[3:0], 1'b0};
      OP_LLB, OP_LHB: imm = {8'h00, ifid_instr[7:0]};
      OP_B:           imm = {{7{ifid_instr[8]}}, ifid_instr[8:0]};
      OP_BR, OP_PCS,
      OP_HLT:         imm = 16'h0000;
      default:        imm = {12'h000, ifid_instr[3:0]};
    endcase
  end

  always_comb begin
    halted      = (state == HALT);
    br_taken    = taken && !halted;
    issue       = ifid_valid && !halted && !stall;
    pc_write_en = !halted && !stall;
    br_sig      = br_taken ? ((op == OP_B) ? BR_REL : BR_REG) : BR_SEQ;
    src_data1   = rf_data1;
    next_state  = state;
    if (issue && (op == OP_HLT)) next_state = HALT;
    idex_next = '0;
    if (issue) begin
      idex_next.valid     = 1'b1;
      idex_next.opcode    = op;
      idex_next.rd        = ifid_instr[11:8];
      idex_next.data1     = rf_data1;
      idex_next.data2     = rf_data2;
      idex_next.imm       = imm;
      idex_next.pc        = ifid_pc;
      idex_next.reg_write = (op < OP_SW) || (op == OP_LLB) || (op == OP_LHB) || (op == OP_PCS);
      idex_next.mem_read  = (op == OP_LW);
      idex_next.mem_write = (op == OP_SW);
      idex_next.halt      = (op == OP_HLT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= 16'h0000;
      idex_q     <= '0;
    end else begin
      state  <= next_state;
      idex_q <= idex_next;
      if (halted || stall) begin
        ifid_valid <= ifid_valid;
      end else if (br_taken) begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end else begin
        ifid_valid <= 1'b1;
        ifid_instr <= if_instr;
        ifid_pc    <= if_pc;
      end
    end
  end

  assign idex_valid     = idex_q.valid;
  assign idex_opcode    = idex_q.opcode;
  assign idex_rd        = idex_q.rd;
  assign idex_data1     = idex_q.data1;
  assign idex_data2     = idex_q.data2;
  assign idex_imm       = idex_q.imm;
  assign idex_pc        = idex_q.pc;
  assign idex_reg_write = idex_q.reg_write;
  assign idex_mem_read  = idex_q.mem_read;
  assign idex_mem_write = idex_q.mem_write;
  assign idex_halt      = idex_q.halt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, ALU/LW/LLB decode, load-use, branches, flag
// hazard and HLT freeze, each step checked against hand-computed values.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] if_pc, if_instr, rf_data1, rf_data2;
  logic [2:0]  flag_bits;
  logic        ex_mem_read, ex_sets_flags;
  logic [3:0]  ex_rd;
  logic [3:0]  rf_addr1, rf_addr2;
  logic        pc_write_en;
  logic [1:0]  br_sig;
  logic [15:0] src_data1;
  logic        idex_valid;
  logic [3:0]  idex_opcode, idex_rd;
  logic [15:0] idex_data1, idex_data2, idex_imm, idex_pc;
  logic        idex_reg_write, idex_mem_read, idex_mem_write, idex_halt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_stage #(.NOP_INSTR(16'h0000)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr), .flag_bits(flag_bits),
    .ex_mem_read(ex_mem_read), .ex_sets_flags(ex_sets_flags), .ex_rd(ex_rd),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .pc_write_en(pc_write_en), .br_sig(br_sig), .src_data1(src_data1),
    .idex_valid(idex_valid), .idex_opcode(idex_opcode), .idex_rd(idex_rd),
    .idex_data1(idex_data1), .idex_data2(idex_data2), .idex_imm(idex_imm),
    .idex_pc(idex_pc), .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
    .idex_mem_write(idex_mem_write), .idex_halt(idex_halt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_instr = 16'h1234; if_pc = 16'h0002; flag_bits = 3'b000;
    ex_mem_read = 1'b0; ex_sets_flags = 1'b0; ex_rd = 4'h0;
    rf_data1 = 16'h0005; rf_data2 = 16'h0007;
    #2;
    chk("rst_idex_valid", {15'd0, idex_valid}, 16'd0);
    chk("rst_pc_write_en", {15'd0, pc_write_en}, 16'd1);
    chk("rst_br_sig", {14'd0, br_sig}, 16'd0);

    // run 1234 into ID/EX, then reset asynchronously mid-cycle
    @(negedge clk); rst = 1'b0;
    tick(); tick();
    chk("pre_rst_idex_valid", {15'd0, idex_valid}, 16'd1);
    chk("pre_rst_idex_rd", {12'd0, idex_rd}, 16'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_idex_valid", {15'd0, idex_valid}, 16'd0);
    chk("async_rst_idex_rd", {12'd0, idex_rd}, 16'd0);
    chk("async_rst_pc_write_en", {15'd0, pc_write_en}, 16'd1);
    chk("async_rst_br_sig", {14'd0, br_sig}, 16'd0);

    // ALU decode 0123 with rf = 5 / 7
    @(negedge clk); rst = 1'b0; if_instr = 16'h0123; if_pc = 16'h0010;
    tick();
    if_instr = 16'h0000; if_pc = 16'h0012;
    #1;
    chk("alu_rf_addr1", {12'd0, rf_addr1}, 16'd2);
    chk("alu_rf_addr2", {12'd0, rf_addr2}, 16'd3);
    tick();
    chk("alu_idex_valid", {15'd0, idex_valid}, 16'd1);
    chk("alu_idex_rd", {12'd0, idex_rd}, 16'd1);
    chk("alu_idex_data1", idex_data1, 16'h0005);
    chk("alu_idex_data2", idex_data2, 16'h0007);
    chk("alu_idex_reg_write", {15'd0, idex_reg_write}, 16'd1);
    chk("alu_idex_pc", idex_pc, 16'h0010);

    // load-use: LW in EX writes r2, 0123 reads r2
    if_instr = 16'h0123; if_pc = 16'h0020;
    tick();
    ex_mem_read = 1'b1; ex_rd = 4'h2; if_instr = 16'h0456; if_pc = 16'h0022;
    #1;
    chk("lu_pc_write_en", {15'd0, pc_write_en}, 16'd0);
    tick();
    chk("lu_bubble_valid", {15'd0, idex_valid}, 16'd0);
    chk("lu_bubble_reg_write", {15'd0, idex_reg_write}, 16'd0);
    ex_mem_read = 1'b0;
    #1;
    chk("lu_release_pc_write_en", {15'd0, pc_write_en}, 16'd1);
    tick();
    chk("lu_issue_valid", {15'd0, idex_valid}, 16'd1);
    chk("lu_issue_rd", {12'd0, idex_rd}, 16'd1);
    chk("lu_issue_pc", idex_pc, 16'h0020);
    // 0456 reads r5/r6; an LW writing r4 is not a hazard
    ex_mem_read = 1'b1; ex_rd = 4'h4;
    #1;
    chk("lu_rd_only_no_stall", {15'd0, pc_write_en}, 16'd1);
    ex_mem_read = 1'b0;

    // B EQ with Z=1: taken, wrong-path slot flushed
    if_instr = 16'hC20A; if_pc = 16'h0030; flag_bits = 3'b100;
    tick();
    if_instr = 16'h0789; if_pc = 16'h0032;
    #1;
    chk("b_taken_br_sig", {14'd0, br_sig}, 16'd1);
    tick();
    chk("b_idex_opcode", {12'd0, idex_opcode}, 16'hC);
    chk("b_idex_imm", idex_imm, 16'h000A);
    chk("b_flushed_br_sig", {14'd0, br_sig}, 16'd0);
    // same branch with Z=0: not taken, no flush
    if_instr = 16'hC20A; if_pc = 16'h0040; flag_bits = 3'b000;
    tick();
    chk("b_flush_bubble", {15'd0, idex_valid}, 16'd0);
    if_instr = 16'h0345; if_pc = 16'h0042;
    #1;
    chk("b_not_taken_br_sig", {14'd0, br_sig}, 16'd0);
    tick();
    chk("b_nt_idex_opcode", {12'd0, idex_opcode}, 16'hC);
    if_instr = 16'hDE30; if_pc = 16'h0050;
    tick();
    chk("b_nt_next_valid", {15'd0, idex_valid}, 16'd1);
    chk("b_nt_next_rd", {12'd0, idex_rd}, 16'd3);

    // BR always with a flag-setting instruction in EX
    ex_sets_flags = 1'b1; rf_data1 = 16'h4444; if_instr = 16'h0111; if_pc = 16'h0052;
    #1;
    chk("br_flag_stall_pc", {15'd0, pc_write_en}, 16'd0);
    chk("br_flag_stall_br_sig", {14'd0, br_sig}, 16'd0);
    tick();
    chk("br_stall_bubble", {15'd0, idex_valid}, 16'd0);
    ex_sets_flags = 1'b0;
    #1;
    chk("br_br_sig", {14'd0, br_sig}, 16'd2);
    chk("br_src_data1", src_data1, 16'h4444);
    chk("br_rf_addr1", {12'd0, rf_addr1}, 16'd3);
    tick();
    chk("br_idex_opcode", {12'd0, idex_opcode}, 16'hD);

    // HLT: issued once, then frozen until rst
    if_instr = 16'hF000; if_pc = 16'h0060;
    tick();
    if_instr = 16'h0123; if_pc = 16'h0062;
    #1;
    chk("hlt_issue_pc_write_en", {15'd0, pc_write_en}, 16'd1);
    tick();
    chk("hlt_idex_halt", {15'd0, idex_halt}, 16'd1);
    chk("hlt_idex_valid", {15'd0, idex_valid}, 16'd1);
    chk("hlt_pc_write_en", {15'd0, pc_write_en}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halted_idex_valid", {15'd0, idex_valid}, 16'd0);
      chk("halted_idex_halt", {15'd0, idex_halt}, 16'd0);
      chk("halted_pc_write_en", {15'd0, pc_write_en}, 16'd0);
    end
    #2 rst = 1'b1;
    #1;
    chk("hlt_rst_pc_write_en", {15'd0, pc_write_en}, 16'd1);

    // after reset: LW 812F then LLB A3C5
    @(negedge clk); rst = 1'b0; if_instr = 16'h812F; if_pc = 16'h0070;
    tick();
    if_instr = 16'hA3C5; if_pc = 16'h0072;
    #1;
    chk("lw_rf_addr1", {12'd0, rf_addr1}, 16'd2);
    chk("lw_rf_addr2", {12'd0, rf_addr2}, 16'd1);
    tick();
    chk("lw_idex_mem_read", {15'd0, idex_mem_read}, 16'd1);
    chk("lw_idex_imm", idex_imm, 16'hFFFE);
    chk("lw_idex_rd", {12'd0, idex_rd}, 16'd1);
    chk("llb_rf_addr1", {12'd0, rf_addr1}, 16'd3);
    tick();
    chk("llb_idex_imm", idex_imm, 16'h00C5);
    chk("llb_idex_mem_read", {15'd0, idex_mem_read}, 16'd0);
    chk("llb_idex_reg_write", {15'd0, idex_reg_write}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
